// File: rtl/spi_host_pkg.sv
// Shared definitions for the SD-card SPI power-up initializer.
package spi_host_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DUMMY   = 3'd1,
    SELECT  = 3'd2,
    CMD     = 3'd3,
    WAIT_R1 = 3'd4,
    RESP    = 3'd5,
    TRAIL   = 3'd6,
    FINISH  = 3'd7
  } state_t;

  // CMD0 (GO_IDLE_STATE): start/tx bits, index 0, zero argument, CRC7 0x4A plus end bit
  localparam logic [47:0] CMD0_FRAME   = 48'h40_0000_0000_95;
  localparam logic [5:0]  CMD_BITS     = 6'd48;
  localparam logic [7:0]  TRAIL_CLOCKS = 8'd8;
  localparam logic [7:0]  R1_BITS_LEFT = 8'd7;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: SCLK idles low and toggles every HALF cycles
// while enabled. rise/fall are one-cycle strobes marking the clock edge on
// which the SCLK register changes level.
module spi_sclk_gen #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] HALF_M1 = 8'(HALF - 1);

  logic [7:0] hcnt;
  logic       tick;

  assign tick = (hcnt == HALF_M1);
  assign rise = en & tick & ~sclk;
  assign fall = en & tick & sclk;

  // half-period counter and SCLK register; disabling parks SCLK low at once
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      hcnt <= 8'd0;
      sclk <= 1'b0;
    end else if (tick) begin
      hcnt <= 8'd0;
      sclk <= ~sclk;
    end else begin
      hcnt <= hcnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_host_initializer.sv
// SD-card SPI power-up sequencer: dummy clocks with CS high, CMD0, R1
// capture with timeout, trailing clocks, then a one-cycle done pulse.
// Rises sample and count; every state change that moves CS or MOSI lands
// on a fall strobe so the card always sees stable data at SCLK rise.
module spi_host_initializer
  import spi_host_pkg::*;
#(
  parameter int CLK_HALF_PERIOD = 2,
  parameter int DUMMY_CLOCKS    = 80,
  parameter int RESP_TIMEOUT    = 64
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       MISO,
  output logic       SCLK,
  output logic       CS,
  output logic       MOSI,
  output logic       busy,
  output logic       done,
  output logic [7:0] R1,
  output logic       timeout
);

  localparam logic [7:0] DUMMY_N = 8'(DUMMY_CLOCKS);
  localparam logic [7:0] RESP_N  = 8'(RESP_TIMEOUT);

  state_t     state, state_n;
  logic       sclk_en, rise, fall;
  logic [7:0] cnt;
  logic [5:0] bidx;
  logic [7:0] rsh;
  logic       got;
  logic       cs_n, mosi_n;
  logic       accept;

  spi_sclk_gen #(.HALF(CLK_HALF_PERIOD)) u_sclk (
    .clk  (CLK),
    .reset(reset),
    .en   (sclk_en),
    .sclk (SCLK),
    .rise (rise),
    .fall (fall)
  );

  // start is only taken when not busy; FINISH counts as not busy
  assign accept = start && (state == IDLE || state == FINISH);

  // state register
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next-state and status decode
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    sclk_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = DUMMY;
      end
      DUMMY: begin
        busy = 1'b1; sclk_en = 1'b1;
        if (fall && cnt == DUMMY_N) state_n = SELECT;
      end
      SELECT: begin
        // entered on a fall, so the next fall closes one full SCLK period
        busy = 1'b1; sclk_en = 1'b1;
        if (fall) state_n = CMD;
      end
      CMD: begin
        busy = 1'b1; sclk_en = 1'b1;
        if (fall && bidx == CMD_BITS) state_n = WAIT_R1;
      end
      WAIT_R1: begin
        busy = 1'b1; sclk_en = 1'b1;
        if (fall) begin
          if (got)                state_n = RESP;
          else if (cnt == RESP_N) state_n = TRAIL;
        end
      end
      RESP: begin
        busy = 1'b1; sclk_en = 1'b1;
        if (fall && cnt == R1_BITS_LEFT) state_n = TRAIL;
      end
      TRAIL: begin
        busy = 1'b1; sclk_en = 1'b1;
        if (fall && cnt == TRAIL_CLOCKS) state_n = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_n = start ? DUMMY : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // next values for the registered CS/MOSI pins
  always_comb begin
    cs_n   = !(state_n == SELECT || state_n == CMD ||
               state_n == WAIT_R1 || state_n == RESP);
    mosi_n = 1'b1;
    if (state_n == CMD) begin
      if (state != CMD)  mosi_n = CMD0_FRAME[47];
      else if (fall)     mosi_n = CMD0_FRAME[6'd47 - bidx];
      else               mosi_n = MOSI;
    end
  end

  // counters, response shifter and result registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt     <= 8'd0;
      bidx    <= 6'd0;
      got     <= 1'b0;
      rsh     <= 8'hFF;
      R1      <= 8'hFF;
      timeout <= 1'b0;
      CS      <= 1'b1;
      MOSI    <= 1'b1;
    end else begin
      CS   <= cs_n;
      MOSI <= mosi_n;
      if (state_n != state) begin
        cnt  <= 8'd0;
        bidx <= 6'd0;
        got  <= 1'b0;
      end else if (rise) begin
        case (state)
          DUMMY, TRAIL: cnt <= cnt + 8'd1;
          CMD:          bidx <= bidx + 6'd1;
          WAIT_R1: begin
            cnt <= cnt + 8'd1;
            rsh <= {rsh[6:0], MISO};
            if (!MISO) got <= 1'b1;
          end
          RESP: begin
            cnt <= cnt + 8'd1;
            rsh <= {rsh[6:0], MISO};
            if (cnt == R1_BITS_LEFT - 8'd1) R1 <= {rsh[6:0], MISO};
          end
          default: ;
        endcase
      end
      if (accept) timeout <= 1'b0;
      if (state == WAIT_R1 && state_n == TRAIL) begin
        timeout <= 1'b1;
        R1      <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_spi_host_initializer.sv
// Directed bench: default instance with an SD-card model, plus a
// CLK/2 instance (card silent) for back-to-back starts.
module tb_spi_host_initializer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       reset, start;
  logic       miso = 1'b1;
  logic       sclk, cs, mosi, busy, done, timeout;
  logic [7:0] r1;

  logic       start2;
  logic       miso2 = 1'b1;
  logic       sclk2, cs2, mosi2, busy2, done2, timeout2;
  logic [7:0] r1_2;

  spi_host_initializer dut (
    .CLK(CLK), .reset(reset), .start(start), .MISO(miso),
    .SCLK(sclk), .CS(cs), .MOSI(mosi), .busy(busy), .done(done),
    .R1(r1), .timeout(timeout)
  );

  spi_host_initializer #(.CLK_HALF_PERIOD(1)) dut2 (
    .CLK(CLK), .reset(reset), .start(start2), .MISO(miso2),
    .SCLK(sclk2), .CS(cs2), .MOSI(mosi2), .busy(busy2), .done(done2),
    .R1(r1_2), .timeout(timeout2)
  );

  int total = 0;
  int bad   = 0;

  // card model / monitor state
  logic        clr;
  logic [63:0] resp_vec;
  int          resp_len;
  logic        sclk_q = 1'b0, sclk2_q = 1'b0;
  int          phase, rises_pre, rises_post, rises_wait, mosi_bad_pre;
  int          ncap, ridx, done_cnt;
  logic [47:0] cmd_cap;
  int          rises2 = 0, bcnt2 = 0, nruns = 0;
  int          run_busy[2];
  int          run_rise[2];

  // card model: capture CMD on SCLK rise, shift response out on SCLK fall
  always @(negedge CLK) begin
    if (clr) begin
      phase = 0; rises_pre = 0; rises_post = 0; rises_wait = 0;
      mosi_bad_pre = 0; ncap = 0; ridx = 0; done_cnt = 0; cmd_cap = '0;
      miso = 1'b1;
    end else begin
      if (!cs && phase == 0) phase = 1;
      if (cs && phase == 1)  phase = 2;
      if (sclk && !sclk_q) begin
        if (cs) begin
          if (phase == 0) begin
            rises_pre++;
            if (!mosi) mosi_bad_pre++;
          end else rises_post++;
        end else if (ncap == 48) rises_wait++;
        else if (ncap > 0 || !mosi) begin
          cmd_cap = {cmd_cap[46:0], mosi};
          ncap++;
        end
      end
      if (!sclk && sclk_q && !cs && ncap == 48) begin
        miso = (ridx < resp_len) ? resp_vec[resp_len-1-ridx] : 1'b1;
        ridx++;
      end
      if (cs) miso = 1'b1;
      if (done) done_cnt++;
    end
    sclk_q = sclk;
    if (sclk2 && !sclk2_q) rises2++;
    if (busy2) bcnt2++;
    if (done2 && nruns < 2) begin
      run_busy[nruns] = bcnt2;
      run_rise[nruns] = rises2;
      nruns++;
      bcnt2  = 0;
      rises2 = 0;
    end
    sclk2_q = sclk2;
  end

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon;
    clr = 1'b1; tick; tick; clr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin tick; n++; end
    chk(tag, done, 1);
  endtask

  task automatic wait_done2(input string tag, input int lim);
    int n = 0;
    while (done2 !== 1'b1 && n < lim) begin tick; n++; end
    chk(tag, done2, 1);
  endtask

  initial begin
    int n;
    int hi;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; clr = 1'b1;
    resp_vec = '0; resp_len = 0;
    repeat (3) tick;

    // reset state
    chk("rst_sclk", sclk, 0);
    chk("rst_cs", cs, 1);
    chk("rst_mosi", mosi, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_r1", r1, 8'hFF);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    tick;

    // silent card: timeout path
    resp_len = 0;
    clear_mon;
    start = 1'b1; tick; start = 1'b0;
    chk("to_busy", busy, 1);
    wait_done("to_done_seen", 3000);
    chk("to_timeout", timeout, 1);
    chk("to_r1", r1, 8'hFF);
    chk("to_pre", rises_pre, 80);
    chk("to_pre_mosi", mosi_bad_pre, 0);
    chk("to_cmd", cmd_cap, 48'h400000000095);
    chk("to_wait", rises_wait, 64);
    chk("to_trail", rises_post, 8);
    tick;
    chk("to_done_cnt", done_cnt, 1);
    chk("to_busy_end", busy, 0);
    repeat (10) tick;
    chk("to_hold_timeout", timeout, 1);
    chk("to_hold_r1", r1, 8'hFF);

    // card answers 0x01 after three idle bytes
    resp_vec = {32'h0, 24'hFFFFFF, 8'h01}; resp_len = 32;
    clear_mon;
    start = 1'b1; tick; start = 1'b0;
    chk("ok_timeout_clr", timeout, 0);
    chk("ok_busy", busy, 1);
    wait_done("ok_done_seen", 3000);
    chk("ok_r1", r1, 8'h01);
    chk("ok_timeout", timeout, 0);
    chk("ok_pre", rises_pre, 80);
    chk("ok_cmd", cmd_cap, 48'h400000000095);
    chk("ok_wait", rises_wait, 32);
    chk("ok_trail", rises_post, 8);
    tick;
    chk("ok_done_cnt", done_cnt, 1);

    // extra starts during DUMMY are ignored
    resp_vec = {48'h0, 8'hFF, 8'h05}; resp_len = 16;
    clear_mon;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (rises_pre < 10 && n < 200) begin tick; n++; end
    chk("ign_reach_dummy", (rises_pre >= 10), 1);
    repeat (5) begin
      start = 1'b1; tick; start = 1'b0;
      repeat (7) tick;
    end
    wait_done("ign_done_seen", 3000);
    chk("ign_pre", rises_pre, 80);
    chk("ign_r1", r1, 8'h05);
    chk("ign_wait", rises_wait, 16);
    tick;
    chk("ign_done_cnt", done_cnt, 1);
    repeat (40) tick;
    chk("ign_busy_after", busy, 0);
    chk("ign_done_cnt_after", done_cnt, 1);

    // reset in the middle of CMD
    clear_mon;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (ncap < 10 && n < 1500) begin tick; n++; end
    chk("mid_reach_cmd", (ncap >= 10), 1);
    reset = 1'b1; tick;
    chk("mid_cs", cs, 1);
    chk("mid_mosi", mosi, 1);
    chk("mid_sclk", sclk, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_r1", r1, 8'hFF);
    reset = 1'b0;
    hi = 0;
    repeat (20) begin tick; if (sclk !== 1'b0) hi++; end
    chk("mid_sclk_quiet", hi, 0);

    // CLK/2 instance: start coincident with done
    start2 = 1'b1; tick; start2 = 1'b0;
    wait_done2("b2b_done1_seen", 1000);
    start2 = 1'b1; tick; start2 = 1'b0;
    chk("b2b_busy_next", busy2, 1);
    wait_done2("b2b_done2_seen", 1000);
    tick;
    chk("b2b_runs", nruns, 2);
    chk("b2b_busy0", run_busy[0], 402);
    chk("b2b_busy1", run_busy[1], 402);
    chk("b2b_rise0", run_rise[0], 201);
    chk("b2b_rise1", run_rise[1], 201);
    chk("b2b_timeout", timeout2, 1);
    chk("b2b_r1", r1_2, 8'hFF);
    chk("b2b_idle", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_host_initializer.md
SPI_HOST_INITIALIZER -- requirements
Module: spi_host_initializer

Interface
REQ-001 SHALL have parameter CLK_HALF_PERIOD, default 2, meaning system-clock cycles per SCLK half-period (range 1..255).
REQ-002 SHALL have parameter DUMMY_CLOCKS, default 80, meaning SCLK cycles sent with CS and MOSI high before the command (range 74..255).
REQ-003 SHALL have parameter RESP_TIMEOUT, default 64, meaning maximum SCLK cycles to wait for an R1 start bit (range 8..255).
REQ-004 SHALL have port `CLK  input  1  system clock`; the block uses one clock, and all logic is on its rising edge.
REQ-005 SHALL have port `reset  input  1  reset`; reset is synchronous and active-high.
REQ-006 SHALL have port `start  input  1  single-cycle request to run the power-up sequence`.
REQ-007 SHALL have port `MISO  input  1  card data out`.
REQ-008 SHALL have port `SCLK  output  1  SPI clock, mode 0, idles low`.
REQ-009 SHALL have port `CS  output  1  chip select, active-low`.
REQ-010 SHALL have port `MOSI  output  1  host data out`.
REQ-011 SHALL have port `busy  output  1  sequence in progress`.
REQ-012 SHALL have port `done  output  1  one-cycle completion pulse`.
REQ-013 SHALL have port `R1  output  8  captured CMD0 response`.
REQ-014 SHALL have port `timeout  output  1  no response within RESP_TIMEOUT; held until next start`.

Function
REQ-015 SHALL implement the states IDLE, DUMMY, SELECT, CMD, WAIT_R1, RESP, TRAIL and FINISH.
REQ-016 SHALL, in IDLE, hold SCLK=0, CS=1 and MOSI=1; `start`=1 SHALL cause busy=1 on the next edge, clear `timeout`, and enter DUMMY.
REQ-017 SHALL toggle SCLK every CLK_HALF_PERIOD cycles in every state except IDLE and FINISH; the "rise" and "fall" strobes SHALL each be one cycle wide.
REQ-018 SHALL, in DUMMY, keep CS=1 and MOSI=1, count SCLK rising edges, and enter SELECT after the DUMMY_CLOCKS-th rise.
REQ-019 SHALL, in SELECT, drive CS=0 and MOSI=1 for exactly one SCLK period, then enter CMD.
REQ-020 SHALL, in CMD, shift the 48-bit frame 0x40_0000_0000_95 MSB first; MOSI SHALL change only on the SCLK fall strobe, and bit 47 SHALL be valid before the first rise.
REQ-021 SHALL enter WAIT_R1 after the 48th rise.
REQ-022 SHALL, in WAIT_R1, hold MOSI=1 and sample MISO on each rise; the first 0 sampled SHALL be R1 bit 7, and the block SHALL enter RESP.
REQ-023 SHALL, if RESP_TIMEOUT rises occur in WAIT_R1 without a 0, set timeout=1 and R1=0xFF, then enter TRAIL.
REQ-024 SHALL, in RESP, capture the remaining 7 bits MSB first on rises; R1 SHALL update only once all 8 bits are captured, and the block SHALL then enter TRAIL.
REQ-025 SHALL, in TRAIL, drive CS=1 and MOSI=1 for 8 SCLK cycles, then enter FINISH with SCLK low.
REQ-026 SHALL, in FINISH, assert done for one cycle and clear busy in the same cycle, then return to IDLE.
REQ-027 SHALL ignore `start` while busy=1.
REQ-028 SHALL let a `start` arriving in the same cycle as the done pulse be honoured on the following cycle.
REQ-029 SHALL hold R1 and timeout stable from FINISH until the next accepted start.

Reset
REQ-030 SHALL, when reset=1, on that rising edge set the state to IDLE and drive SCLK=0, CS=1, MOSI=1, busy=0, done=0, R1=0xFF and timeout=0, and clear all counters.
REQ-031 SHALL give reset priority over start.
REQ-032 SHALL abort a sequence cleanly on reset in any state, with no further SCLK edges.

Structure
REQ-033 SHALL define the state enumeration, the 48-bit CMD0 frame constant and the TRAIL length (8) in a shared package spi_host_pkg.
REQ-034 SHALL place SCLK generation (half-period counter, SCLK register, rise/fall strobes, enable input) in sub-module spi_sclk_gen.
REQ-035 SHALL keep the bit and timeout counters 8 bits wide, and 6 bits wide for the CMD bit index.

Verification
REQ-036 SHALL verify: reset asserted mid-CMD -> next cycle CS=1, MOSI=1, SCLK=0, busy=0, R1=0xFF, and SCLK stays low for 20 cycles.
REQ-037 SHALL verify, with default parameters: start, card model drives MISO=1 -> exactly 80 SCLK rises with CS=1 and MOSI=1 before CS falls.
REQ-038 SHALL verify: card returns 0x01 after 3 idle bytes -> R1=0x01, timeout=0, MOSI shows 0x40,0x00,0x00,0x00,0x00,0x95, done pulses once.
REQ-039 SHALL verify: MISO held at 1 -> after 64 rises in WAIT_R1, timeout=1, R1=0xFF, 8 trailing clocks, done pulses.
REQ-040 SHALL verify: start pulsed 5 times during DUMMY -> a single sequence, DUMMY count unaffected.
REQ-041 SHALL verify, with CLK_HALF_PERIOD=1 (SCLK=CLK/2): start coincident with done -> second sequence begins on the next cycle and completes identically.
